rv_mdu: RTL and testbench
=========================

RV_MDU -- requirements
Module: rv_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 supported.
REQ-002 SHALL have port clk_i  input  1  core clock; all state updates on rising edge.
REQ-003 SHALL have port arstn_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mdu_req_i  input  1  single-cycle start pulse.
REQ-005 SHALL have port mdu_op_i  input  3  operation code, MDU_MUL..MDU_REMU from rv_mdu_pkg.
REQ-006 SHALL have port mdu_port_a_i  input  XLEN  rs1 operand / dividend.
REQ-007 SHALL have port mdu_port_b_i  input  XLEN  rs2 operand / divisor.
REQ-008 SHALL have port mdu_kill_i  input  1  abort the current operation (pipeline flush).
REQ-009 SHALL have port mdu_result_o  output  XLEN  registered result.
REQ-010 SHALL have port mdu_valid_o  output  1  one-cycle result strobe.
REQ-011 SHALL have port mdu_busy_o  output  1  operation in flight; the core stalls on it.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL accept a request only in IDLE with mdu_req_i=1 and mdu_kill_i=0; mdu_req_i in CALC/DONE SHALL be ignored.
REQ-014 SHALL latch op, operand magnitudes and result-sign flags on the accepting edge.
REQ-015 SHALL for iterative ops go IDLE->CALC, run exactly 32 iterations under a 5-bit counter, then CALC->DONE.
REQ-016 SHALL for single-cycle cases go IDLE->DONE directly.
REQ-017 SHALL go DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL assert mdu_valid_o exactly while in DONE.
REQ-019 SHALL drive mdu_busy_o = (state != IDLE).
REQ-020 SHALL load mdu_result_o on entry to DONE and hold it until the next entry to DONE.
REQ-021 SHALL give latency, accepting edge to valid cycle: 33 cycles iterative; 1 cycle single-cycle.
REQ-022 SHALL compute MUL/MULH/MULHSU/MULHU as the low/high 32 bits of the 64-bit product, operands sign-extended per op (MULHSU: a signed, b unsigned).
REQ-023 SHALL divide with a restoring radix-2 algorithm on unsigned magnitudes, with sign fix applied when entering DONE.
REQ-024 SHALL give the quotient the sign a^b and the remainder the sign of the dividend.
REQ-025 SHALL handle divide by zero in a single cycle: DIV/DIVU -> 0xFFFFFFFF, REM/REMU -> dividend.
REQ-026 SHALL handle signed overflow (0x80000000 / 0xFFFFFFFF) in a single cycle: DIV -> 0x80000000, REM -> 0.
REQ-027 SHALL treat mdu_kill_i=1 in CALC or DONE as forcing IDLE at the next edge, with no valid strobe that cycle or later and mdu_result_o unchanged.
REQ-028 SHALL give mdu_kill_i priority over mdu_req_i when both are high in IDLE (request not accepted).

Reset
REQ-029 SHALL, while arstn_i=0, force state IDLE, counter 0, mdu_result_o 0, mdu_valid_o 0, mdu_busy_o 0, independent of clk_i.
REQ-030 SHALL discard an in-flight operation on reset mid-operation, with no valid strobe after release.

Configuration
REQ-031 SHALL, with macro MDU_FAST_MUL_EN defined, execute all four multiply ops through a single-cycle 33x33 signed multiplier (IDLE->DONE, latency 1).
REQ-032 SHALL, without MDU_FAST_MUL_EN, execute multiplies as 32-step shift-add on magnitudes with sign fix (latency 33); division SHALL be iterative in both builds.

Structure
REQ-033 SHALL place the state enum typedef (mdu_state_e) and MDU_ITER_NUM = 32 in rv_mdu_pkg alongside the existing op codes.
REQ-034 SHALL use one combinational sub-module, rv_mdu_div_step, performing one restoring-division iteration (shift, trial subtract, quotient bit); the shift-add multiply step SHALL stay inline.

Verification
REQ-035 SHALL cover MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB, valid 33 cycles after accept (1 with MDU_FAST_MUL_EN); busy high throughout.
REQ-036 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-037 SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, each valid after 33 cycles.
REQ-038 SHALL cover DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0; each valid after 1 cycle.
REQ-039 SHALL cover a DIVU started then mdu_kill_i pulsed at CALC cycle 10 -> no valid, busy low next cycle, result unchanged; a new MUL request is then accepted and completes correctly.
REQ-040 SHALL cover arstn_i asserted asynchronously mid-CALC -> all outputs 0 immediately; mdu_req_i during busy ignored (no second valid).

Source files
------------

// File: rtl/rv_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, FSM states,
// iteration count and the conditional-negate helpers used for sign fix-up.
package rv_mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    localparam int unsigned MDU_ITER_NUM = 32;
    localparam logic [4:0]  MDU_CNT_LAST = 5'(MDU_ITER_NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    function automatic logic [31:0] neg_if32(input logic neg, input logic [31:0] val);
        return neg ? (32'd0 - val) : val;
    endfunction

    function automatic logic [63:0] neg_if64(input logic neg, input logic [63:0] val);
        return neg ? (64'd0 - val) : val;
    endfunction

endpackage

// File: rtl/rv_mdu_div_step.sv
// One restoring radix-2 division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and emit one quotient bit.
module rv_mdu_div_step
    import rv_mdu_pkg::*;
(
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted_s;
    logic [32:0] diff_s;

    assign shifted_s = {rem_i, quo_i[31]};
    assign diff_s    = shifted_s - {1'b0, divisor_i};
    // A borrow out of bit 32 means the trial subtract failed: keep the shifted value.
    assign rem_o     = diff_s[32] ? shifted_s[31:0] : diff_s[31:0];
    assign quo_o     = {quo_i[30:0], ~diff_s[32]};

endmodule

// File: rtl/rv_mdu.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide
// on magnitudes. Define MDU_FAST_MUL_EN for single-cycle multiplies.
module rv_mdu
    import rv_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            mdu_req_i,
    input  logic [2:0]      mdu_op_i,
    input  logic [XLEN-1:0] mdu_port_a_i,
    input  logic [XLEN-1:0] mdu_port_b_i,
    input  logic            mdu_kill_i,
    output logic [XLEN-1:0] mdu_result_o,
    output logic            mdu_valid_o,
    output logic            mdu_busy_o
);

    mdu_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] b_q, b_d;
    logic        neg_q, neg_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic        valid_q, busy_q;

    logic        a_signed_s, b_signed_s, a_neg_s, b_neg_s, is_div_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_acc_s, mul_prod_s, div_acc_s;
    logic [31:0] div_rem_s, div_quo_s, fix_res_s;

    assign is_div_s   = mdu_op_i[2];
    assign a_signed_s = (mdu_op_i == MDU_MUL) || (mdu_op_i == MDU_MULH) || (mdu_op_i == MDU_MULHSU)
                     || (mdu_op_i == MDU_DIV) || (mdu_op_i == MDU_REM);
    assign b_signed_s = (mdu_op_i == MDU_MUL) || (mdu_op_i == MDU_MULH)
                     || (mdu_op_i == MDU_DIV) || (mdu_op_i == MDU_REM);
    assign a_neg_s    = a_signed_s & mdu_port_a_i[31];
    assign b_neg_s    = b_signed_s & mdu_port_b_i[31];
    assign a_mag_s    = neg_if32(a_neg_s, mdu_port_a_i);
    assign b_mag_s    = neg_if32(b_neg_s, mdu_port_b_i);

    // Shift-add step: acc[31:0] holds the remaining multiplier bits, acc[63:32] the partial sum.
    assign mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_acc_s  = {mul_sum_s, acc_q[31:1]};
    assign mul_prod_s = neg_if64(neg_q, mul_acc_s);

    rv_mdu_div_step u_div_step (
        .rem_i     (acc_q[63:32]),
        .quo_i     (acc_q[31:0]),
        .divisor_i (b_q),
        .rem_o     (div_rem_s),
        .quo_o     (div_quo_s)
    );
    assign div_acc_s = {div_rem_s, div_quo_s};

`ifdef MDU_FAST_MUL_EN
    logic signed [32:0] fast_a_s, fast_b_s;
    logic signed [63:0] fast_prod_s;
    logic [31:0]        fast_res_s;
    assign fast_a_s    = {a_neg_s, mdu_port_a_i};
    assign fast_b_s    = {b_neg_s, mdu_port_b_i};
    assign fast_prod_s = fast_a_s * fast_b_s;
    assign fast_res_s  = (mdu_op_i == MDU_MUL) ? fast_prod_s[31:0] : fast_prod_s[63:32];
`endif

    // Final-iteration result with sign fix applied as the FSM enters DONE.
    always_comb begin
        fix_res_s = 32'd0;
        if (op_q[2]) begin
            fix_res_s = neg_if32(neg_q, op_q[1] ? div_rem_s : div_quo_s);
        end else if (op_q == MDU_MUL) begin
            fix_res_s = mul_prod_s[31:0];
        end else begin
            fix_res_s = mul_prod_s[63:32];
        end
    end

    // Next-state, operand capture and result load.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        b_d      = b_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (mdu_req_i && !mdu_kill_i) begin
                    op_d  = mdu_op_i;
                    b_d   = b_mag_s;
                    neg_d = (is_div_s && mdu_op_i[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
                    acc_d = {32'd0, a_mag_s};
                    cnt_d = 5'd0;
                    if (is_div_s && (mdu_port_b_i == 32'd0)) begin
                        result_d = mdu_op_i[1] ? mdu_port_a_i : 32'hFFFF_FFFF;
                        state_d  = DONE;
                    end else if (is_div_s && !mdu_op_i[0] && (mdu_port_a_i == 32'h8000_0000)
                                 && (mdu_port_b_i == 32'hFFFF_FFFF)) begin
                        result_d = mdu_op_i[1] ? 32'd0 : 32'h8000_0000;
                        state_d  = DONE;
`ifdef MDU_FAST_MUL_EN
                    end else if (!is_div_s) begin
                        result_d = fast_res_s;
                        state_d  = DONE;
`endif
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (mdu_kill_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = op_q[2] ? div_acc_s : mul_acc_s;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == MDU_CNT_LAST) begin
                        result_d = fix_res_s;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered output flags.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            b_q      <= 32'd0;
            neg_q    <= 1'b0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            valid_q  <= (state_d == DONE);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign mdu_result_o = result_q;
    assign mdu_valid_o  = valid_q;
    assign mdu_busy_o   = busy_q;

endmodule

// File: tb/tb_rv_mdu.sv
// Scoreboard bench for rv_mdu: expected results are queued at request time and
// popped when mdu_valid_o strobes. Honours MDU_FAST_MUL_EN for multiply latency.
module tb_rv_mdu;
    import rv_mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        arstn, req, kill;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] result;
    logic        valid, busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = 32'd0;

    rv_mdu #(.XLEN(32)) dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .mdu_req_i    (req),
        .mdu_op_i     (op),
        .mdu_port_a_i (a),
        .mdu_port_b_i (b),
        .mdu_kill_i   (kill),
        .mdu_result_o (result),
        .mdu_valid_o  (valid),
        .mdu_busy_o   (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, ux, uy, p;
        logic signed [31:0] qx, qy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'd0, x};
        uy = {32'd0, y};
        qx = x;
        qy = y;
        case (o)
            MDU_MUL:    begin p = sx * sy; return p[31:0];  end
            MDU_MULH:   begin p = sx * sy; return p[63:32]; end
            MDU_MULHSU: begin p = sx * uy; return p[63:32]; end
            MDU_MULHU:  begin p = ux * uy; return p[63:32]; end
            MDU_DIV:    return (y == 32'd0) ? 32'hFFFF_FFFF :
                               ((x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)) ? 32'h8000_0000 : 32'(qx / qy);
            MDU_DIVU:   return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            MDU_REM:    return (y == 32'd0) ? x :
                               ((x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)) ? 32'd0 : 32'(qx % qy);
            default:    return (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (!o[2]) return MUL_LAT;
        if (y == 32'd0) return 1;
        if (!o[0] && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)) return 1;
        return DIV_LAT;
    endfunction

    task automatic wait_valid(output int lat, output bit busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        while ((valid !== 1'b1) && (lat < 60)) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output bit busy_ok, output logic [31:0] got,
                          output logic [31:0] want);
        @(negedge clk);
        req = 1'b1; op = o; a = x; b = y;
        exp_q.push_back(model(o, x, y));
        @(negedge clk);
        req = 1'b0;
        wait_valid(lat, busy_ok);
        got  = result;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        last_exp = want;
    endtask

    task automatic test_reset();
        arstn = 1'b1; req = 1'b0; kill = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        #3 arstn = 1'b0;
        #1;
        n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        repeat (2) @(negedge clk);
        arstn = 1'b1;
    endtask

    task automatic run_table(input string name, input logic [2:0] ops[4], input logic [31:0] xs[4],
                             input logic [31:0] ys[4], input logic [31:0] wants[4], input int lats[4]);
        int lat; bit busy_ok; logic [31:0] got, want;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], xs[i], ys[i], lat, busy_ok, got, want);
            n_tests++;
            if ((got !== want) || (want !== wants[i])) begin
                n_fail++; $display("FAIL %s[%0d]_result got=%h exp=%h", name, i, got, wants[i]);
            end
            n_tests++;
            if (lat != lats[i]) begin n_fail++; $display("FAIL %s[%0d]_latency got=%0d exp=%0d", name, i, lat, lats[i]); end
            n_tests++;
            if (!busy_ok) begin n_fail++; $display("FAIL %s[%0d]_busy got=low exp=high", name, i); end
            @(negedge clk);
            n_tests++;
            if ((valid !== 1'b0) || (busy !== 1'b0)) begin
                n_fail++; $display("FAIL %s[%0d]_done_1cyc got=v%b/b%b exp=v0/b0", name, i, valid, busy);
            end
        end
    endtask

    task automatic test_mul();
        run_table("mul", '{MDU_MUL, MDU_MULH, MDU_MULHU, MDU_MULHSU},
                  '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                  '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                  '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF},
                  '{MUL_LAT, MUL_LAT, MUL_LAT, MUL_LAT});
    endtask

    task automatic test_div();
        run_table("div", '{MDU_DIV, MDU_REM, MDU_DIVU, MDU_REMU},
                  '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100},
                  '{32'h0000_0002, 32'h0000_0002, 32'd7, 32'd7},
                  '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2},
                  '{DIV_LAT, DIV_LAT, DIV_LAT, DIV_LAT});
    endtask

    task automatic test_div_special();
        run_table("divspec", '{MDU_DIVU, MDU_REMU, MDU_DIV, MDU_REM},
                  '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000},
                  '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                  '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0},
                  '{1, 1, 1, 1});
    endtask

    task automatic test_kill();
        int lat, vcnt; bit busy_ok; logic [31:0] got, want, held;
        held = last_exp;
        @(negedge clk);
        req = 1'b1; op = MDU_DIVU; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        req = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy got=%b exp=0", busy); end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL kill_valid got=%b exp=0", valid); end
        n_tests++; if (result !== held) begin n_fail++; $display("FAIL kill_result got=%h exp=%h", result, held); end
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (valid === 1'b1) vcnt++; end
        n_tests++; if (vcnt != 0) begin n_fail++; $display("FAIL kill_no_valid got=%0d exp=0", vcnt); end
        run_op(MDU_MUL, 32'h0000_1234, 32'h0000_0010, lat, busy_ok, got, want);
        n_tests++; if (got !== 32'h0001_2340) begin n_fail++; $display("FAIL kill_then_mul got=%h exp=00012340", got); end
        n_tests++; if (lat != MUL_LAT) begin n_fail++; $display("FAIL kill_then_mul_lat got=%0d exp=%0d", lat, MUL_LAT); end
    endtask

    task automatic test_async_reset();
        int vcnt;
        @(negedge clk);
        req = 1'b1; op = MDU_DIVU; a = 32'd12345; b = 32'd11;
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        #2 arstn = 1'b0;
        #1;
        n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL arst_result got=%h exp=0", result); end
        n_tests++; if ((valid !== 1'b0) || (busy !== 1'b0)) begin
            n_fail++; $display("FAIL arst_flags got=v%b/b%b exp=v0/b0", valid, busy);
        end
        @(negedge clk);
        arstn = 1'b1;
        last_exp = 32'd0;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (valid === 1'b1) vcnt++; end
        n_tests++; if (vcnt != 0) begin n_fail++; $display("FAIL arst_no_valid got=%0d exp=0", vcnt); end
    endtask

    task automatic test_req_ignored();
        int vcnt;
        logic [31:0] got;
        @(negedge clk);
        req = 1'b1; op = MDU_DIVU; a = 32'd100; b = 32'd7;
        exp_q.push_back(model(MDU_DIVU, 32'd100, 32'd7));
        @(negedge clk);
        req = 1'b0;
        vcnt = 0;
        got = 32'd0;
        for (int cyc = 1; cyc < 50; cyc++) begin
            req = 1'b0;
            if (valid === 1'b1) begin
                vcnt++;
                got = result;
                if (exp_q.size() > 0) last_exp = exp_q.pop_front();
            end
            if ((cyc == 5) || ((valid === 1'b1) && (vcnt == 1))) begin
                req = 1'b1; op = MDU_MUL; a = 32'd3; b = 32'd4;
            end
            @(negedge clk);
        end
        req = 1'b0;
        n_tests++; if (vcnt != 1) begin n_fail++; $display("FAIL busy_req_valid_count got=%0d exp=1", vcnt); end
        n_tests++; if ((got !== 32'd14) || (last_exp !== 32'd14)) begin
            n_fail++; $display("FAIL busy_req_result got=%h exp=0000000e", got);
        end
    endtask

    task automatic test_random();
        int lat; bit busy_ok; logic [31:0] got, want, x, y; logic [2:0] o;
        for (int i = 0; i < 12; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom();
            y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
            if (i == 3) y = 32'd1;
            run_op(o, x, y, lat, busy_ok, got, want);
            n_tests++;
            if (got !== want) begin
                n_fail++; $display("FAIL rand[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, got, want);
            end
            n_tests++;
            if (lat != exp_lat(o, x, y)) begin
                n_fail++; $display("FAIL rand[%0d]_latency got=%0d exp=%0d", i, lat, exp_lat(o, x, y));
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_kill();
        test_async_reset();
        test_req_ignored();
        test_random();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
